// File: rtl/tic_tac_toe_pkg.sv
// Shared definitions for the tic-tac-toe pushbutton conditioner.
//   db_state_e   : per-button debouncer states
//   IDX_*        : bit positions of each button in the 5-bit vectors {C,D,U,R,L}
//   PRIO_ORDER   : arbitration order, highest priority first (C > U > D > L > R)
//   prio_grant() : one-hot grant of the highest-priority requesting button
package tic_tac_toe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned IDX_L   = 0;
  localparam int unsigned IDX_R   = 1;
  localparam int unsigned IDX_U   = 2;
  localparam int unsigned IDX_D   = 3;
  localparam int unsigned IDX_C   = 4;

  localparam int unsigned PRIO_ORDER [NUM_BTN] = '{IDX_C, IDX_U, IDX_D, IDX_L, IDX_R};

  function automatic logic [NUM_BTN-1:0] prio_grant(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] gnt;
    logic               found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (!found && req[PRIO_ORDER[i]]) begin
        gnt[PRIO_ORDER[i]] = 1'b1;
        found              = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/tic_tac_toe_debouncer.sv
// Single-button conditioner: 2-flop synchroniser, debounce FSM and stability
// counter. Optional auto-repeat when BTN_AUTOREPEAT_EN is defined.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button, active-high
//   level_o : debounced level (PRESSED or RELEASE_WAIT)
//   event_o : combinational press/repeat event, registered by the arbiter
module tic_tac_toe_debouncer
  import tic_tac_toe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          REPEAT_EN       = 1'b1
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic event_o
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_ev;

  assign s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    press_ev = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = PRESSED;
          press_ev = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCW  = (RMAX > 2) ? $clog2(RMAX) : 1;

  logic [RCW-1:0] rpt_q, rpt_d;
  logic           first_q, first_d;
  logic           rpt_ev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end

  // Counts only while staying in PRESSED; the first period is REPEAT_DELAY,
  // later ones REPEAT_RATE. Any other state restarts the delay.
  always_comb begin
    rpt_d   = '0;
    first_d = 1'b1;
    rpt_ev  = 1'b0;
    if (REPEAT_EN && (state_q == PRESSED) && s) begin
      first_d = first_q;
      rpt_d   = rpt_q + 1'b1;
      if (rpt_q == (first_q ? RCW'(REPEAT_DELAY - 1) : RCW'(REPEAT_RATE - 1))) begin
        rpt_ev  = 1'b1;
        rpt_d   = '0;
        first_d = 1'b0;
      end
    end
  end

  assign event_o = press_ev | rpt_ev;
`else
  assign event_o = press_ev;
`endif

endmodule

// File: rtl/tic_tac_toe_btn_cond.sv
// Pushbutton conditioner for the tic-tac-toe game FSM. Five debouncers feed a
// one-deep pending register per button; a fixed-priority arbiter (C>U>D>L>R)
// grants at most one registered one-cycle pulse per clock.
// Optional macro: BTN_AUTOREPEAT_EN (auto-repeat on L/R/U/D).
//   Clk                 : system clock
//   reset_n             : asynchronous active-low reset
//   u_BtnL..u_BtnC      : raw buttons, active-high
//   BtnL..BtnC          : one-cycle press pulses, at most one high per cycle
//   DPB[4:0]            : debounced levels {C,D,U,R,L}
module tic_tac_toe_btn_cond
  import tic_tac_toe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_RATE     = 5000000
`endif
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       u_BtnL,
  input  logic       u_BtnR,
  input  logic       u_BtnU,
  input  logic       u_BtnD,
  input  logic       u_BtnC,
  output logic       BtnL,
  output logic       BtnR,
  output logic       BtnU,
  output logic       BtnD,
  output logic       BtnC,
  output logic [4:0] DPB
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] ev;
  logic [NUM_BTN-1:0] req, grant;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [NUM_BTN-1:0] out_q;

  assign raw = {u_BtnC, u_BtnD, u_BtnU, u_BtnR, u_BtnL};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    tic_tac_toe_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (g != IDX_C)
`endif
    ) u_db (
      .clk_i   (Clk),
      .rst_ni  (reset_n),
      .btn_i   (raw[g]),
      .level_o (DPB[g]),
      .event_o (ev[g])
    );
  end

  // New events join the pending set before arbitration so an uncontended
  // press is granted in the same cycle it arrives.
  always_comb begin
    req    = pend_q | ev;
    grant  = prio_grant(req);
    pend_d = req & ~grant;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      out_q  <= '0;
    end else begin
      pend_q <= pend_d;
      out_q  <= grant;
    end
  end

  assign BtnL = out_q[IDX_L];
  assign BtnR = out_q[IDX_R];
  assign BtnU = out_q[IDX_U];
  assign BtnD = out_q[IDX_D];
  assign BtnC = out_q[IDX_C];

endmodule

// File: tb/tb_tic_tac_toe_btn_cond.sv
// Self-checking bench for tic_tac_toe_btn_cond: directed scenarios plus random
// button activity, compared every cycle against a run-length/queue model.
module tb_tic_tac_toe_btn_cond;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       u_BtnL = 1'b0, u_BtnR = 1'b0, u_BtnU = 1'b0, u_BtnD = 1'b0, u_BtnC = 1'b0;
  logic       BtnL, BtnR, BtnU, BtnD, BtnC;
  logic [4:0] DPB;
  logic [4:0] pulses;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  tic_tac_toe_btn_cond #(
    .DEBOUNCE_CYCLES (D)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
`endif
  ) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .u_BtnL  (u_BtnL),
    .u_BtnR  (u_BtnR),
    .u_BtnU  (u_BtnU),
    .u_BtnD  (u_BtnD),
    .u_BtnC  (u_BtnC),
    .BtnL    (BtnL),
    .BtnR    (BtnR),
    .BtnU    (BtnU),
    .BtnD    (BtnD),
    .BtnC    (BtnC),
    .DPB     (DPB)
  );

  assign pulses = {BtnC, BtnD, BtnU, BtnR, BtnL};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_raw(input logic [4:0] v);
    {u_BtnC, u_BtnD, u_BtnU, u_BtnR, u_BtnL} = v;
  endtask

  // Reference model: a button's accepted level flips once the synchronised
  // input has differed from it on D+1 consecutive edges; press events queue
  // in a pending set drained one per cycle in priority order.
  int         prio [5] = '{4, 2, 3, 0, 1};
  bit         h1 [5], h2 [5], lvl [5], pend [5];
  int         run [5], t [5];
  logic [4:0] exp_out = '0, exp_dpb = '0;

  always @(posedge Clk or negedge reset_n) begin
    logic [4:0] rawv;
    bit         sv, ev, was_pressed, done;
    if (!reset_n) begin
      for (int b = 0; b < 5; b++) begin
        h1[b] = 0; h2[b] = 0; lvl[b] = 0; pend[b] = 0; run[b] = 0; t[b] = 0;
      end
      exp_out = '0;
      exp_dpb = '0;
    end else begin
      rawv = {u_BtnC, u_BtnD, u_BtnU, u_BtnR, u_BtnL};
      for (int b = 0; b < 5; b++) begin
        sv    = h2[b];
        h2[b] = h1[b];
        h1[b] = rawv[b];
        ev    = 0;
        was_pressed = lvl[b] && (run[b] == 0);
        if (sv != lvl[b]) begin
          run[b]++;
          if (run[b] == D + 1) begin
            lvl[b] = sv;
            run[b] = 0;
            ev     = sv;
          end
        end else begin
          run[b] = 0;
        end
`ifdef BTN_AUTOREPEAT_EN
        if (b != 4 && was_pressed && sv) begin
          t[b]++;
          if (t[b] == RD || (t[b] > RD && (t[b] - RD) % RR == 0)) ev = 1;
        end else begin
          t[b] = 0;
        end
`else
        t[b] = was_pressed ? 1 : 0;
`endif
        if (ev) pend[b] = 1;
        exp_dpb[b] = lvl[b];
      end
      exp_out = '0;
      done    = 0;
      for (int i = 0; i < 5; i++) begin
        if (!done && pend[prio[i]]) begin
          exp_out[prio[i]] = 1'b1;
          pend[prio[i]]    = 0;
          done             = 1;
        end
      end
    end
  end

  int npulse [5] = '{0, 0, 0, 0, 0};

  always @(negedge Clk) begin
    if (reset_n) begin
      for (int b = 0; b < 5; b++) npulse[b] += int'(pulses[b]);
      check("model_out", {27'd0, pulses}, {27'd0, exp_out});
      check("model_dpb", {27'd0, DPB}, {27'd0, exp_dpb});
    end
  end

  initial begin
    int         base0, base1, base2, base4;
    logic       dpb_seen;
    logic [4:0] five_exp [5];
    logic [4:0] r;
    int         thr;
    five_exp = '{5'b10000, 5'b00100, 5'b01000, 5'b00001, 5'b00010};

    // Reset state
    set_raw('0);
    repeat (3) @(negedge Clk);
    check("rst_out", {27'd0, pulses}, 32'd0);
    check("rst_dpb", {27'd0, DPB}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge Clk);

    // R press latency: sampled at edge k, pulse after edge k+6
    set_raw(5'b00010);
    repeat (6) @(posedge Clk);
    #1 check("r_pre", {27'd0, pulses}, 32'd0);
    check("r_pre_dpb", {27'd0, DPB}, 32'd0);
    @(posedge Clk);
    #1 check("r_pulse", {27'd0, pulses}, 32'b00010);
    check("r_dpb", {27'd0, DPB}, 32'b00010);
    @(posedge Clk);
    #1 check("r_post", {27'd0, pulses}, 32'd0);
    @(posedge Clk);
    base1 = npulse[1];
    // Release with single-cycle bounces
    repeat (8) @(negedge Clk);
    set_raw(5'b00000); @(negedge Clk);
    set_raw(5'b00010); @(negedge Clk);
    set_raw(5'b00000); @(negedge Clk);
    set_raw(5'b00010); @(negedge Clk);
    set_raw(5'b00000);
    repeat (20) @(posedge Clk);
    check("bounce_pulses", npulse[1] - base1, 0);
    #1 check("bounce_dpb", {27'd0, DPB}, 32'd0);

    // L glitch of 3 cycles
    @(negedge Clk);
    base0 = npulse[0];
    set_raw(5'b00001);
    repeat (3) @(negedge Clk);
    set_raw('0);
    dpb_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clk);
      #1 dpb_seen |= DPB[0];
    end
    check("glitch_pulses", npulse[0] - base0, 0);
    check("glitch_dpb", {31'd0, dpb_seen}, 32'd0);

    // All five on the same edge
    @(negedge Clk);
    set_raw(5'b11111);
    repeat (6) @(posedge Clk);
    #1 check("five_pre", {27'd0, pulses}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1 check($sformatf("five_%0d", i), {27'd0, pulses}, {27'd0, five_exp[i]});
    end
    @(posedge Clk);
    #1 check("five_post", {27'd0, pulses}, 32'd0);
    @(negedge Clk);
    set_raw('0);
    repeat (15) @(negedge Clk);

    // Async reset during D PRESS_WAIT, button kept held
    set_raw(5'b01000);
    repeat (4) @(posedge Clk);
    #2 reset_n = 1'b0;
    #1 check("arst_out", {27'd0, pulses}, 32'd0);
    check("arst_dpb", {27'd0, DPB}, 32'd0);
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
    repeat (6) @(posedge Clk);
    #1 check("arst_pre", {27'd0, pulses}, 32'd0);
    @(posedge Clk);
    #1 check("arst_pulse", {27'd0, pulses}, 32'b01000);
    @(negedge Clk);
    set_raw('0);
    repeat (15) @(negedge Clk);

    // Long holds of U and C
    @(posedge Clk);
    base2 = npulse[2];
    base4 = npulse[4];
    @(negedge Clk);
    set_raw(5'b00100);
    repeat (60) @(negedge Clk);
    set_raw(5'b10000);
    repeat (60) @(negedge Clk);
    set_raw('0);
    repeat (20) @(posedge Clk);
`ifdef BTN_AUTOREPEAT_EN
    check("hold_u_pulses", npulse[2] - base2, 6);
`else
    check("hold_u_pulses", npulse[2] - base2, 1);
`endif
    check("hold_c_pulses", npulse[4] - base4, 1);

    // Random activity with varying toggle density
    r   = '0;
    thr = 10;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if (c % 50 == 0) begin
        case ($urandom_range(2))
          0:       thr = 3;
          1:       thr = 10;
          default: thr = 30;
        endcase
      end
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(thr - 1) == 0) r[b] = ~r[b];
      end
      set_raw(r);
    end
    set_raw('0);
    repeat (40) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tic_tac_toe_btn_cond.md
Name: tic_tac_toe_btn_cond

Overview:
Conditions the five raw board pushbuttons (L, R, U, D, C) into clean single-clock-enable pulses for the tic-tac-toe game FSM. Per button, it synchronises the input, debounces it and emits one pulse per press. An arbiter guarantees at most one pulse per clock, so the game FSM never sees simultaneous cursor/select events. Sits directly upstream of the game FSM; its pulse outputs drive the FSM's BtnL/BtnR/BtnU/BtnD/BtnC inputs.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles input must stay stable before a press/release is accepted (>=2)
REPEAT_DELAY, 12500000, hold cycles before first auto-repeat pulse (BTN_AUTOREPEAT_EN only)
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses (BTN_AUTOREPEAT_EN only)

Ports:
Clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
u_BtnL  input  1  raw asynchronous left button, active-high
u_BtnR  input  1  raw right button
u_BtnU  input  1  raw up button
u_BtnD  input  1  raw down button
u_BtnC  input  1  raw centre/select button
BtnL  output  1  one-cycle press pulse, left
BtnR  output  1  one-cycle press pulse, right
BtnU  output  1  one-cycle press pulse, up
BtnD  output  1  one-cycle press pulse, down
BtnC  output  1  one-cycle press pulse, select
DPB  output  5  debounced levels {C,D,U,R,L}, high while button accepted as pressed

Behaviour:
- Reset (reset_n low, any time incl. mid-press): all outputs 0, synchronisers 0, all debouncers to IDLE, counters 0, pending bits 0. A button still held at release of reset must satisfy a full debounce before any pulse.
- Synchroniser: 2-flop per button; debouncer sees s = second flop.
- Debouncer FSM per button, counter width clog2(DEBOUNCE_CYCLES):
  IDLE: s=1 -> PRESS_WAIT, cnt<=0.
  PRESS_WAIT: s=0 -> IDLE; cnt==DEBOUNCE_CYCLES-1 -> PRESSED, raise press event; else cnt+1.
  PRESSED: s=0 -> RELEASE_WAIT, cnt<=0.
  RELEASE_WAIT: s=1 -> PRESSED (no new event); cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
  DPB bit = 1 in PRESSED and RELEASE_WAIT.
- Latency: raw rising edge sampled at edge k with stable input -> press event at edge k+2+DEBOUNCE_CYCLES; uncontended pulse output high for the cycle after that edge (registered).
- Glitches shorter than DEBOUNCE_CYCLES: no event, no DPB change.
- Arbiter: each press event sets a pending bit (one-deep; a second event for an already-pending button is dropped). Each cycle the highest-priority pending bit is granted and cleared; priority C > U > D > L > R. Outputs are one-hot or zero every cycle. Pending bit set and granted in the same cycle when uncontended (no added latency).
- Five simultaneous events -> pulses on five consecutive cycles in priority order.

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined: for L/R/U/D only, a repeat counter runs while in PRESSED; first extra event at REPEAT_DELAY cycles after entry to PRESSED, then every REPEAT_RATE cycles; counter clears on leaving PRESSED. Events go through the arbiter like presses. C never repeats.
- Undefined: exactly one event per press; repeat counters and parameters unused/removed.

Decomposition:
- Package tic_tac_toe_pkg: debouncer state encodings (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT), button index constants (IDX_L=0, IDX_R=1, IDX_U=2, IDX_D=3, IDX_C=4), arbiter priority order.
- Sub-module tic_tac_toe_debouncer: synchroniser + FSM + counter (+ repeat counter when enabled), outputs level and event; instantiated 5x. Arbiter and output registers remain in the top.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8):
- u_BtnR high at edge 10, held 30 cycles -> BtnR high exactly one cycle after edge 16, DPB[1]=1 from then; no other pulses.
- u_BtnL 3-cycle glitch -> no BtnL pulse, DPB stays 0; same with 1-cycle bounces during release of a held button -> no second pulse.
- All five raw inputs rise on the same edge -> BtnC, BtnU, BtnD, BtnL, BtnR on five consecutive cycles, never two high together.
- reset_n pulsed low while u_BtnD in PRESS_WAIT -> outputs 0 immediately (async); with button still held, BtnD fires 2+4 cycles after reset_n deasserts.
- BTN_AUTOREPEAT_EN: hold u_BtnU 60 cycles -> initial pulse, next at +20, then every 8; hold u_BtnC -> single pulse only. Without macro -> single pulse for both.
